// File: rtl/alu_sequencer.sv
// Multi-cycle controller in front of a combinational 16-bit ALU: iterates single-bit shifts,
// owns the PSR, and with ALU_SEQ_CARRY_EN defined adds a second pass for carry-in ops.
module alu_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_opcode,
   input  logic [3:0]       req_opext,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [3:0]       req_count,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_opcode,
   output logic [3:0]       alu_opext,
   input  logic [WIDTH-1:0] alu_s,
   input  logic [4:0]       alu_flags,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [4:0]       res_flags,
   output logic [4:0]       psr_flags
);

`ifdef ALU_SEQ_CARRY_EN
   typedef enum logic [2:0] {IDLE, EXEC, SHIFT, ZERO, CARRY, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, EXEC, SHIFT, ZERO, DONE} state_t;
`endif

   state_t           state_reg, state_next;
   logic [3:0]       op_reg, ext_reg;
   logic [WIDTH-1:0] a_reg;          // operand A, shift accumulator, or first-pass sum
   logic [WIDTH-1:0] b_reg;
   logic [3:0]       count_reg;      // shift passes still to run
   logic [WIDTH-1:0] res_data_reg, res_data_next;
   logic [4:0]       res_flags_reg, res_flags_next;
   logic [4:0]       psr_reg;
   logic             load_res;
`ifdef ALU_SEQ_CARRY_EN
   logic             cin_reg;
   logic [4:0]       pass_flags_reg;
`endif

   function automatic logic is_shift(input logic [3:0] op, input logic [3:0] ext);
      return (op == 4'b1000) || (op == 4'b1110) || ({op, ext} == 8'b0000_1110) ||
             ({op, ext} == 8'b1010_0001) || ({op, ext} == 8'b1010_0100);
   endfunction

`ifdef ALU_SEQ_CARRY_EN
   function automatic logic is_carry(input logic [3:0] op, input logic [3:0] ext);
      return (op == 4'b0111) || ({op, ext} == 8'b0000_0111) ||
             ({op, ext} == 8'b1010_0101) || ({op, ext} == 8'b1010_0110);
   endfunction
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      req_ready      = 1'b0;
      res_valid      = 1'b0;
      alu_a          = '0;
      alu_b          = '0;
      alu_opcode     = 4'b0000;
      alu_opext      = 4'b0000;
      load_res       = 1'b0;
      res_data_next  = res_data_reg;
      res_flags_next = res_flags_reg;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (is_shift(req_opcode, req_opext)) begin
                  state_next = (req_count == 4'd0) ? ZERO : SHIFT;
               end else begin
                  state_next = EXEC;
               end
            end
         end
         EXEC: begin
            alu_a      = a_reg;
            alu_b      = b_reg;
            alu_opcode = op_reg;
            alu_opext  = ext_reg;
`ifdef ALU_SEQ_CARRY_EN
            if (cin_reg) begin
               state_next = CARRY;
            end else
`endif
            begin
               state_next     = DONE;
               load_res       = 1'b1;
               res_data_next  = alu_s;
               res_flags_next = alu_flags;
            end
         end
         SHIFT: begin
            alu_a      = a_reg;
            alu_b      = b_reg;
            alu_opcode = op_reg;
            alu_opext  = ext_reg;
            if (count_reg == 4'd1) begin
               state_next     = DONE;
               load_res       = 1'b1;
               res_data_next  = alu_s;
               res_flags_next = alu_flags;
            end
         end
         ZERO: begin
            state_next     = DONE;
            load_res       = 1'b1;
            res_data_next  = a_reg;
            res_flags_next = 5'b00000;
         end
`ifdef ALU_SEQ_CARRY_EN
         CARRY: begin
            // Second pass adds the carry-in with ADDU; overflow is reported from the first pass
            alu_a          = a_reg;
            alu_b          = WIDTH'(1);
            alu_opcode     = 4'b0000;
            alu_opext      = 4'b0110;
            state_next     = DONE;
            load_res       = 1'b1;
            res_data_next  = alu_s;
            res_flags_next = {pass_flags_reg[4] | alu_flags[4], 1'b0, pass_flags_reg[2],
                              alu_flags[1], 1'b0};
         end
`endif
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_reg         <= 4'b0000;
         ext_reg        <= 4'b0000;
         a_reg          <= '0;
         b_reg          <= '0;
         count_reg      <= 4'd0;
         res_data_reg   <= '0;
         res_flags_reg  <= 5'b00000;
         psr_reg        <= 5'b00000;
`ifdef ALU_SEQ_CARRY_EN
         cin_reg        <= 1'b0;
         pass_flags_reg <= 5'b00000;
`endif
      end else begin
         res_data_reg  <= res_data_next;
         res_flags_reg <= res_flags_next;
         if (load_res) begin
            psr_reg <= res_flags_next;
         end
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  op_reg    <= req_opcode;
                  ext_reg   <= req_opext;
                  a_reg     <= req_a;
                  b_reg     <= req_b;
                  count_reg <= req_count;
`ifdef ALU_SEQ_CARRY_EN
                  cin_reg   <= is_carry(req_opcode, req_opext) & psr_reg[4];
`endif
               end
            end
`ifdef ALU_SEQ_CARRY_EN
            EXEC: begin
               a_reg          <= alu_s;
               pass_flags_reg <= alu_flags;
            end
`endif
            SHIFT: begin
               a_reg     <= alu_s;
               count_reg <= count_reg - 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign res_data  = res_data_reg;
   assign res_flags = res_flags_reg;
   assign psr_flags = psr_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a combinational ALU model on the ALU port, a table of directed
// vectors, hand-written backpressure/reset sequences, and random ops against a reference model.
module tb_alu_sequencer;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  ext;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  cnt;
      logic [15:0] d;
      logic [4:0]  f;
      int          lat;
      bit          noalu;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_opcode = 4'h0;
   logic [3:0]  req_opext = 4'h0;
   logic [15:0] req_a = 16'h0;
   logic [15:0] req_b = 16'h0;
   logic [3:0]  req_count = 4'h0;
   logic [15:0] alu_a, alu_b, alu_s;
   logic [3:0]  alu_opcode, alu_opext;
   logic [4:0]  alu_flags;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [15:0] res_data;
   logic [4:0]  res_flags;
   logic [4:0]  psr_flags;

   int          checks = 0;
   int          failures = 0;
   logic [4:0]  psr_model = 5'b0;

   alu_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_opext(req_opext),
      .req_a(req_a), .req_b(req_b), .req_count(req_count),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_opext(alu_opext),
      .alu_s(alu_s), .alu_flags(alu_flags),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_flags(res_flags), .psr_flags(psr_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Single-pass ALU model: returns {CLFZN, S}
   function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op, input logic [3:0] ext);
      logic [16:0] sum;
      logic [15:0] s;
      logic [4:0]  f;
      s = 16'h0;
      f = 5'b0;
      sum = 17'h0;
      if (op == 4'h7 || {op, ext} inside {8'h05, 8'h06, 8'h07, 8'hA5, 8'hA6}) begin
         sum  = {1'b0, a} + {1'b0, b};
         s    = sum[15:0];
         f[4] = sum[16];
         f[2] = (a[15] == b[15]) && (s[15] != a[15]);
         f[1] = (s == 16'h0);
      end else if ({op, ext} == 8'h09) begin
         s    = a - b;
         f[4] = (a < b);
         f[2] = (a[15] != b[15]) && (s[15] != a[15]);
         f[1] = (s == 16'h0);
      end else if ({op, ext} inside {8'h01, 8'h02, 8'h03}) begin
         s    = (ext == 4'h1) ? (a & b) : (ext == 4'h2) ? (a | b) : (a ^ b);
         f[1] = (s == 16'h0);
      end else if ({op, ext} == 8'h0B) begin
         f[3] = (a < b);
         f[1] = (a == b);
         f[0] = ($signed(a) < $signed(b));
      end else if (op == 4'h8 || {op, ext} == 8'hA1) begin
         s = {a[14:0], 1'b0};
      end else if (op == 4'hE || {op, ext} == 8'h0E) begin
         s = {1'b0, a[15:1]};
      end else if ({op, ext} == 8'hA4) begin
         s = {a[15], a[15:1]};
      end
      return {f, s};
   endfunction

   assign {alu_flags, alu_s} = alu_fn(alu_a, alu_b, alu_opcode, alu_opext);

   function automatic bit tb_is_shift(input logic [3:0] op, input logic [3:0] ext);
      return (op == 4'h8) || (op == 4'hE) || ({op, ext} inside {8'h0E, 8'hA1, 8'hA4});
   endfunction

   function automatic bit tb_is_carry(input logic [3:0] op, input logic [3:0] ext);
      return (op == 4'h7) || ({op, ext} inside {8'h07, 8'hA5, 8'hA6});
   endfunction

   // Whole-op reference: shifts as multi-bit arithmetic, carry ops as a + b + cin
   function automatic vec_t ref_model(input vec_t v);
      vec_t        r;
      logic [16:0] sum;
      logic [15:0] s1;
      r       = v;
      r.noalu = 1'b0;
      r.lat   = 2;
      r.f     = 5'b0;
      sum     = 17'h0;
      s1      = v.a + v.b;
      if (tb_is_shift(v.op, v.ext)) begin
         if (v.op == 4'h8 || {v.op, v.ext} == 8'hA1) r.d = v.a << v.cnt;
         else if ({v.op, v.ext} == 8'hA4)           r.d = 16'($signed(v.a) >>> v.cnt);
         else                                       r.d = v.a >> v.cnt;
         r.lat   = (v.cnt == 4'd0) ? 2 : int'(v.cnt) + 1;
         r.noalu = (v.cnt == 4'd0);
      end else if (tb_is_carry(v.op, v.ext) && psr_model[4]) begin
`ifdef ALU_SEQ_CARRY_EN
         sum   = {1'b0, v.a} + {1'b0, v.b} + 17'd1;
         r.d   = sum[15:0];
         r.f   = {sum[16], 1'b0, (v.a[15] == v.b[15]) && (s1[15] != v.a[15]),
                  sum[15:0] == 16'h0, 1'b0};
         r.lat = 3;
`else
         {r.f, r.d} = alu_fn(v.a, v.b, v.op, v.ext);
`endif
      end else begin
         {r.f, r.d} = alu_fn(v.a, v.b, v.op, v.ext);
      end
      return r;
   endfunction

   function automatic vec_t mk(input logic [7:0] opx, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] cnt, input logic [15:0] d, input logic [4:0] f,
                               input int lat, input bit noalu);
      vec_t v;
      v.op = opx[7:4]; v.ext = opx[3:0]; v.a = a; v.b = b; v.cnt = cnt;
      v.d = d; v.f = f; v.lat = lat; v.noalu = noalu;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input int hold, input string tag);
      int cyc;
      bit seen;
      @(negedge clk);
      check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
      req_opcode = v.op; req_opext = v.ext; req_a = v.a; req_b = v.b; req_count = v.cnt;
      req_valid  = 1'b1;
      res_ready  = (hold == 0);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_a = 16'($urandom); req_b = 16'($urandom); req_count = 4'($urandom);
      req_opcode = 4'($urandom); req_opext = 4'($urandom);
      cyc  = 0;
      seen = 1'b0;
      do begin
         @(negedge clk);
         cyc++;
         if (alu_opcode != 4'h0 || alu_opext != 4'h0) seen = 1'b1;
      end while (!res_valid && cyc < 40);
      check({tag, " latency"}, 32'(cyc), 32'(v.lat));
      check({tag, " res_data"}, 32'(res_data), 32'(v.d));
      check({tag, " res_flags"}, 32'(res_flags), 32'(v.f));
      check({tag, " psr_flags"}, 32'(psr_flags), 32'(v.f));
      if (v.noalu) check({tag, " alu idle on count 0"}, 32'(seen), 32'd0);
      $display("%s op=%h_%h a=%h b=%h cnt=%0d res=%h flags=%b lat=%0d hold=%0d",
               tag, v.op, v.ext, v.a, v.b, v.cnt, res_data, res_flags, cyc, hold);
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         check({tag, " held res_valid"}, 32'(res_valid), 32'd1);
         check({tag, " held res_data"}, 32'(res_data), 32'(v.d));
         res_ready = 1'b1;
      end
      psr_model = v.f;
   endtask

   vec_t        vecs [13];
   logic [7:0]  opsel [18] = '{8'h05, 8'h06, 8'h07, 8'h70, 8'hA5, 8'hA6, 8'h01, 8'h02, 8'h03,
                              8'h09, 8'h0B, 8'h84, 8'h80, 8'h0E, 8'hE0, 8'hA1, 8'hA4, 8'h00};

   initial begin
      vecs[0]  = mk(8'h05, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 5'b00100, 2,  1'b0);
      vecs[1]  = mk(8'h84, 16'h0001, 16'h0000, 4'd4,  16'h0010, 5'b00000, 5,  1'b0);
      vecs[2]  = mk(8'hE0, 16'h8000, 16'h0000, 4'd15, 16'h0001, 5'b00000, 16, 1'b0);
      vecs[3]  = mk(8'h06, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 5'b10010, 2,  1'b0);
`ifdef ALU_SEQ_CARRY_EN
      vecs[4]  = mk(8'h07, 16'h0001, 16'h0002, 4'd0,  16'h0004, 5'b00000, 3,  1'b0);
`else
      vecs[4]  = mk(8'h07, 16'h0001, 16'h0002, 4'd0,  16'h0003, 5'b00000, 2,  1'b0);
`endif
      vecs[5]  = mk(8'h84, 16'h1234, 16'h5555, 4'd0,  16'h1234, 5'b00000, 2,  1'b1);
      vecs[6]  = mk(8'hA4, 16'h8000, 16'h0000, 4'd3,  16'hF000, 5'b00000, 4,  1'b0);
      vecs[7]  = mk(8'h01, 16'hF0F0, 16'h0FF0, 4'd0,  16'h00F0, 5'b00000, 2,  1'b0);
      vecs[8]  = mk(8'h07, 16'h0001, 16'h0002, 4'd0,  16'h0003, 5'b00000, 2,  1'b0);
      vecs[9]  = mk(8'h06, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 5'b10010, 2,  1'b0);
`ifdef ALU_SEQ_CARRY_EN
      vecs[10] = mk(8'hA6, 16'h7FFF, 16'h0000, 4'd0,  16'h8000, 5'b00000, 3,  1'b0);
`else
      vecs[10] = mk(8'hA6, 16'h7FFF, 16'h0000, 4'd0,  16'h7FFF, 5'b00000, 2,  1'b0);
`endif
      vecs[11] = mk(8'h06, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 5'b10010, 2,  1'b0);
`ifdef ALU_SEQ_CARRY_EN
      vecs[12] = mk(8'h73, 16'hFFFF, 16'h0000, 4'd0,  16'h0000, 5'b10010, 3,  1'b0);
`else
      vecs[12] = mk(8'h73, 16'hFFFF, 16'h0000, 4'd0,  16'hFFFF, 5'b00000, 2,  1'b0);
`endif

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset res_valid", 32'(res_valid), 32'd0);
      check("reset res_data", 32'(res_data), 32'd0);
      check("reset res_flags", 32'(res_flags), 32'd0);
      check("reset psr_flags", 32'(psr_flags), 32'd0);
      check("reset alu_a", 32'(alu_a), 32'd0);
      check("reset alu_b", 32'(alu_b), 32'd0);
      check("reset alu_op", 32'({alu_opcode, alu_opext}), 32'd0);

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i], i % 2, $sformatf("vec%0d", i));
      end

      // Backpressure: result held for 10 cycles, a request pulse in the window is ignored
      begin
         int cyc;
         @(negedge clk);
         req_opcode = 4'h0; req_opext = 4'h5; req_a = 16'h0003; req_b = 16'h0004;
         req_count = 4'd0; req_valid = 1'b1; res_ready = 1'b0;
         @(posedge clk);
         #1 req_valid = 1'b0;
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!res_valid && cyc < 10);
         check("bp latency", 32'(cyc), 32'd2);
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp res_valid", 32'(res_valid), 32'd1);
            check("bp res_data", 32'(res_data), 32'h0007);
            check("bp res_flags", 32'(res_flags), 32'd0);
            check("bp req_ready", 32'(req_ready), 32'd0);
            if (i == 4) begin
               req_opcode = 4'h0; req_opext = 4'h1; req_a = 16'hFFFF; req_b = 16'hFFFF;
               req_valid = 1'b1;
            end else begin
               req_valid = 1'b0;
            end
         end
         res_ready = 1'b1;
         $display("bp op=0_5 a=0003 b=0004 res=%h flags=%b held=10", res_data, res_flags);
         @(negedge clk);
         check("bp after handshake req_ready", 32'(req_ready), 32'd1);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp no queued op", 32'(res_valid), 32'd0);
         end
         psr_model = 5'b0;
      end

      // Reset in the third pass of a count-8 shift, with a nonzero PSR beforehand
      run_op(mk(8'h05, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 5'b00100, 2, 1'b0), 0, "prime");
      @(negedge clk);
      req_opcode = 4'h8; req_opext = 4'h4; req_a = 16'h0001; req_b = 16'h5555;
      req_count = 4'd8; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("midshift acc", 32'(alu_a), 32'h0004);
      reset = 1'b1;
      #1;
      check("midrst req_ready", 32'(req_ready), 32'd1);
      check("midrst res_valid", 32'(res_valid), 32'd0);
      check("midrst res_data", 32'(res_data), 32'd0);
      check("midrst res_flags", 32'(res_flags), 32'd0);
      check("midrst psr_flags", 32'(psr_flags), 32'd0);
      check("midrst alu_a", 32'(alu_a), 32'd0);
      check("midrst alu_b", 32'(alu_b), 32'd0);
      check("midrst alu_op", 32'({alu_opcode, alu_opext}), 32'd0);
      $display("midrst reset during shift pass 3: req_ready=%b res_valid=%b psr=%b",
               req_ready, res_valid, psr_flags);
      @(negedge clk);
      reset = 1'b0;
      psr_model = 5'b0;
      @(negedge clk);
      check("post-reset req_ready", 32'(req_ready), 32'd1);
      check("post-reset res_valid", 32'(res_valid), 32'd0);

      for (int n = 0; n < 60; n++) begin
         vec_t       v;
         logic [7:0] sel;
         sel   = opsel[$urandom_range(0, 17)];
         v     = mk(sel, 16'h0, 16'h0, 4'd0, 16'h0, 5'b0, 2, 1'b0);
         if (sel == 8'h70 || sel == 8'h80 || sel == 8'hE0) v.ext = 4'($urandom);
         v.a   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         v.b   = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
         v.cnt = 4'($urandom);
         v     = ref_model(v);
         run_op(v, $urandom_range(0, 2), $sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller sitting between instruction decode and the combinational 16-bit ALU. It accepts one operation at a time over a valid/ready handshake, drives the ALU's A/B/opcode/opext inputs, and iterates the ALU's single-bit shift for multi-bit shift counts. It optionally adds a second carry pass for add-with-carry ops. It registers the result and flags and owns the processor status flags register (PSR).

## Interface
- `WIDTH`, 16, datapath width; only 16 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  operation request.
- `req_ready`  out  1  high when the sequencer can accept a request (state IDLE).
- `req_opcode`  in  4  ALU opcode.
- `req_opext`  in  4  ALU opcode extension.
- `req_a`, `req_b`  in  16  operands.
- `req_count`  in  4  shift amount (0–15); ignored for non-shift ops.
- `alu_a`, `alu_b`  out  16  registered-state-driven ALU operands.
- `alu_opcode`, `alu_opext`  out  4  ALU op select.
- `alu_s`  in  16  ALU result.
- `alu_flags`  in  5  ALU CLFZN: [4]=C, [3]=L, [2]=F, [1]=Z, [0]=N.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  16  result.
- `res_flags`  out  5  flags of this op.
- `psr_flags`  out  5  PSR, the CLFZN of the last completed op.

## Operation
- **Shift ops:**
  - The shift ops are LSH 1000_0100, LSHI 1000_xxxx, RSH 0000_1110, RSHI 1110_xxxx, ALSH 1010_0001 and ARSH 1010_0100.
  - A shift op runs `req_count` single-bit ALU passes.
- **Carry ops:** ADDC 0000_0111, ADDCI 0111_xxxx, ADDCU 1010_0101, ADDCUI 1010_0110.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch opcode, opext, A, B and count. For carry ops, also latch `psr_flags[4]` as cin.
  - Next state:
    - shift op with count 0 → ZERO
    - shift op with count > 0 → SHIFT, with remaining=count and acc=A
    - carry op → EXEC
    - any other op → EXEC
- **EXEC:**
  - Drive the latched A, B, opcode and opext; capture `alu_s` and `alu_flags`.
  - If `CARRY_EN` logic applies (see Configuration) and cin=1 → CARRY. Otherwise → DONE.
- **SHIFT:**
  - Drive `alu_a`=acc, `alu_b`=latched B, and the latched opcode/opext.
  - Each cycle: acc←`alu_s`, remaining−1.
  - When remaining==1 at the edge → DONE. Flags = `alu_flags` of the final pass (all zero).
- **ZERO:** `res_data`←latched A, flags←0 → DONE. The ALU is not exercised.
- **CARRY:**
  - Drive `alu_a`=first-pass S, `alu_b`=1, op 0000_0110 (ADDU).
  - Capture S. C = C1 | C2. Z from the second pass. F from the first pass. L=N=0.
  - → DONE.
- **DONE:**
  - `res_valid`=1, with `res_data`/`res_flags` stable.
  - The PSR is loaded with `res_flags` on the same edge DONE is entered.
  - On `res_ready` → IDLE.
- **ALU drive outside EXEC/SHIFT/CARRY:** A=B=0, opcode/opext=0000_0000 (ALU default, S=0).
- **Ignored inputs:** `req_valid` in any state other than IDLE is ignored; no queueing.

## Timing
- **Reset values:**
  - state IDLE
  - `req_ready`=1
  - `res_valid`=0
  - `res_data`=0
  - `res_flags`=0
  - `psr_flags`=0
  - all `alu_*` outputs=0
- **Latency (accept edge k):**
  - single-pass op / count 0: `res_valid` from edge k+2 (EXEC or ZERO cycle, then DONE).
  - shift count N: `res_valid` from edge k+N+1.
  - carry op with second pass: `res_valid` from edge k+3.
- **Handshakes:**
  - A request transfers when `req_valid` & `req_ready` at a rising edge.
  - A result transfers when `res_valid` & `res_ready`.
  - With `res_ready` held low, the block stays in DONE indefinitely with outputs stable.
  - The earliest next accept is the cycle after the result handshake. `req_ready` is 0 in the DONE cycle.
- **Reset mid-operation:** immediately aborts. The in-flight op is lost and the PSR is cleared.

## Configuration
- `ALU_SEQ_CARRY_EN`
  - **Defined:** carry ops with latched cin=1 take the CARRY pass as above.
  - **Undefined:** carry ops are single-pass EXEC ops. Result and flags are exactly the ALU's output, so the carry-in is effectively 0. The CARRY state is not built.

## Test plan
- **ADD overflow:** ADD 0000_0101, A=0x7FFF, B=0x0001 → `res_data`=0x8000, `res_flags`[2]=1, `res_valid` 2 cycles after accept. PSR=0b00100.
- **Multi-bit shifts:**
  - LSH 1000_0100, A=0x0001, count 4 → 0x0010, `res_valid` at accept+5.
  - RSHI 1110_0000, A=0x8000, count 15 → 0x0001.
- **Carry chain:**
  - ADDU 0x FFFF+0x0001 → S=0, C=1, Z=1.
  - Then ADDC 0x0001+0x0002 → 0x0004, C=0, at accept+3 with `ALU_SEQ_CARRY_EN`; 0x0003 at accept+2 without.
- **Count 0:** LSH, A=0x1234, count 0 → 0x1234, flags 0, no nonzero `alu_opcode` observed.
- **Backpressure:**
  - Hold `res_ready`=0 for 10 cycles → `res_valid`, data and flags stable; `req_ready`=0.
  - A `req_valid` pulse in this window is not accepted.
- **Reset mid-shift:** assert `reset` during the 3rd pass of a count-8 shift → all outputs at reset values on the same cycle. After release, `req_ready`=1.
